serial_subtractor_8bit: RTL and testbench

SERIAL_SUBTRACTOR_8BIT -- requirements
Module: serial_subtractor_8bit

---
 rtl/serial_subtractor_8bit.sv | 111 +++++++++++
 tb/tb_serial_subtractor_8bit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_8bit.sv
// -----------------------------------------------------------------------------
// serial_subtractor_8bit
//
// Bit-serial 8-bit subtractor. One full-subtractor stage is reused, LSB first,
// one bit per clock. An accepted start latches the operands and the borrow-in.
// Eight RUN cycles follow. The result is then published on D/bout, and done
// pulses for one cycle.
//
// Ports
//   clk    in   1  rising-edge clock
//   rst    in   1  synchronous, active-high reset
//   start  in   1  request a new subtraction (honoured in IDLE and DONE only)
//   A      in   8  minuend, sampled on the accepting edge
//   B      in   8  subtrahend, sampled on the accepting edge
//   bin    in   1  borrow-in, sampled on the accepting edge
//   D      out  8  A - B - bin (mod 256) of the last completed operation
//   bout   out  1  borrow-out of the last completed operation (A < B + bin)
//   busy   out  1  high while in RUN
//   done   out  1  one-cycle pulse in DONE; D/bout are valid for that op
// -----------------------------------------------------------------------------
module serial_subtractor_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       bin,
  output logic [7:0] D,
  output logic       bout,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic [7:0] a_q, b_q;   // latched operands, indexed by the bit counter
  logic [7:0] res_q;      // partial difference, shifts right as bits arrive
  logic       br_q;       // running borrow
  logic [2:0] cnt_q;      // index of the bit processed on the next edge

  // Single full-subtractor stage shared by all eight bits.
  logic a_i, b_i, d_i, br_n;
  always_comb begin
    a_i  = a_q[cnt_q];
    b_i  = b_q[cnt_q];
    d_i  = a_i ^ b_i ^ br_q;
    br_n = (~a_i & b_i) | (~(a_i ^ b_i) & br_q);
  end

  // A new operation may begin from IDLE, or back-to-back from DONE.
  // Requests that arrive during RUN are dropped.
  logic accept;
  assign accept = start && ((state == IDLE) || (state == DONE));

  // busy/done are kept as flops that are loaded with the next-state decode.
  // They therefore equal (state==RUN) and (state==DONE) without
  // combinational decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      res_q <= 8'h00;
      br_q  <= 1'b0;
      cnt_q <= 3'd0;
      D     <= 8'h00;
      bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (accept) begin
            a_q   <= A;
            b_q   <= B;
            br_q  <= bin;
            res_q <= 8'h00;
            cnt_q <= 3'd0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          // The partial result stays internal. D only changes at completion,
          // so the previous answer stays visible for the whole run.
          res_q <= {d_i, res_q[7:1]};
          br_q  <= br_n;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            D     <= {d_i, res_q[7:1]};
            bout  <= br_n;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor_8bit
//
// Directed vectors with hand-computed results, reset/abort, ignored-start and
// back-to-back scenarios. A random sweep follows, checked against a 9-bit
// A-B-bin reference.
// -----------------------------------------------------------------------------
module tb_serial_subtractor_8bit;

  logic       clk = 1'b0;
  logic       rst, start, bin;
  logic [7:0] A, B, D;
  logic       bout, busy, done;

  int checks   = 0;
  int failures = 0;

  serial_subtractor_8bit dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .bin(bin),
    .D(D), .bout(bout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive a request before the next edge, then release it and scramble the
  // operands. A change after the accepting edge must not reach the result.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bi);
    A = a; B = b; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = ~a; B = ~b; bin = ~bi;
  endtask

  // Count cycles from the accepting edge until done is seen (sampled on
  // negedge). Also capture D mid-run so the hold check can compare against it.
  task automatic wait_done(output int n, output logic [7:0] mid_d);
    n = 0; mid_d = D;
    while (!done && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (n == 4) mid_d = D;
    end
  endtask

  logic [7:0] last_d = 8'h00;

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bi, input logic [7:0] ed, input logic eb);
    int n; logic [7:0] mid;
    start_op(a, b, bi);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    wait_done(n, mid);
    chk({tag, ".lat"}, n, 8);
    chk({tag, ".hold"}, {24'd0, mid}, {24'd0, last_d});
    chk({tag, ".D"}, {24'd0, D}, {24'd0, ed});
    chk({tag, ".bout"}, {31'd0, bout}, {31'd0, eb});
    chk({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, ".pulse"}, {31'd0, done}, 32'd0);
    last_d = ed;
  endtask

  initial begin
    int n, gap; logic [7:0] mid, ra, rb; logic rbi; logic [8:0] ref9;
    rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.state", {28'd0, busy, done, bout, |D}, 32'd0);
    rst = 1'b0;

    // Directed vectors, applied in the first cycle after reset release.
    run_op("v05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    run_op("v00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run_op("vFF_FF", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_op("v80_7F", 8'h80, 8'h7F, 1'b0, 8'h01, 1'b0);
    run_op("v10_0F", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
    run_op("vAA_55", 8'hAA, 8'h55, 1'b0, 8'h55, 1'b0);

    // Start during RUN is ignored: 05-03 must finish with a single done.
    @(negedge clk);
    start_op(8'h05, 8'h03, 1'b0);              // accepted at edge k
    @(posedge clk); @(negedge clk);            // after k+1
    @(posedge clk); @(negedge clk);            // after k+2
    A = 8'hAA; B = 8'h55; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;          // edge k+3
    n = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) begin
        n++;
        chk("ign.D", {24'd0, D}, 32'h02);
        chk("ign.bout", {31'd0, bout}, 32'd0);
      end
      @(posedge clk);
    end
    chk("ign.pulses", n, 1);
    last_d = 8'h02;

    // Reset mid-run at edge k+4: everything cleared, and no done appears.
    @(negedge clk);
    start_op(8'h80, 8'h01, 1'b0);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort.state", {28'd0, busy, done, bout, |D}, 32'd0);
    rst = 1'b0;
    last_d = 8'h00;
    // Any leftover done would arrive early and break the latency check.
    run_op("post_rst", 8'h33, 8'h44, 1'b1, 8'hEE, 1'b1);

    // Back-to-back: start stays high into DONE with the second operands.
    @(negedge clk);
    A = 8'h05; B = 8'h03; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    A = 8'h10; B = 8'h20; bin = 1'b1;          // start stays high during RUN
    wait_done(n, mid);
    chk("b2b.lat1", n, 8);
    chk("b2b.D1", {24'd0, D}, 32'h02);
    @(posedge clk); #1;                        // accepted in DONE
    start = 1'b0;
    wait_done(gap, mid);
    chk("b2b.gap", gap + 1, 9);
    chk("b2b.D2", {24'd0, D}, 32'hEF);
    chk("b2b.bout2", {31'd0, bout}, 32'd1);

    // Random sweep against a 9-bit reference.
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
      start_op(ra, rb, rbi);
      wait_done(n, mid);
      chk("rnd.lat", n, 8);
      chk("rnd.res", {23'd0, bout, D}, {23'd0, ref9[8], ref9[7:0]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
